// File: rtl/sextium_io.sv
// sextium_io: syscall I/O unit for the Sextium III core.
// Executes HALT, READ and WRITE syscalls. READ and WRITE exchange decimal
// ASCII text over byte-stream handshakes.
module sextium_io (
   input  logic        clock,
   input  logic        reset,
   input  logic        runio,
   input  logic [15:0] acc,
   input  logic [15:0] dr,
   output logic        iobusy,
   output logic        halted,
   output logic [15:0] io_result,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   typedef enum logic [3:0] {
      IDLE, HALTED, W_SIGN, W_DIGIT, W_EMIT, W_NL, R_SKIP, R_DIGIT, DONE
   } state_t;

   state_t      state, state_next;

   logic [15:0] code_q;     // latched syscall code
   logic        neg_q;      // WRITE: value negative; READ: negate flag
   logic [16:0] mag_q;      // WRITE magnitude being converted
   logic [2:0]  pos_q;      // decimal position, 0 = ten-thousands
   logic [3:0]  cnt_q;      // current digit value
   logic        lead_q;     // a significant digit has already been emitted
   logic        nl_sent_q;  // final LF has been placed on tx
   logic [15:0] val_q;      // READ accumulator

   logic        start;
   logic [16:0] divisor;
   logic [16:0] mag_rem;
   logic        mag_ge;
   logic        tx_free;
   logic        emit_digit;
   logic        rx_fire;
   logic        rx_is_ws;
   logic        rx_is_digit;
   logic        rx_is_minus;
   logic [15:0] val_acc;

   assign start       = (state == IDLE) && runio && !iobusy;
   assign mag_rem     = mag_q - divisor;
   assign mag_ge      = (mag_q >= divisor);
   assign tx_free     = !tx_valid || tx_ready;
   assign emit_digit  = (cnt_q != 4'd0) || lead_q || (pos_q == 3'd4);
   assign rx_fire     = rx_valid && rx_ready;
   assign rx_is_ws    = (rx_data == 8'h20) || (rx_data == 8'h09) ||
                        (rx_data == 8'h0A) || (rx_data == 8'h0D);
   assign rx_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign rx_is_minus = (rx_data == 8'h2D);
   assign val_acc     = val_q * 16'd10 + {12'd0, rx_data[3:0]};

   // Power-of-ten subtrahend for the current decimal position
   always_comb begin
      divisor = 17'd1;
      case (pos_q)
         3'd0:    divisor = 17'd10000;
         3'd1:    divisor = 17'd1000;
         3'd2:    divisor = 17'd100;
         3'd3:    divisor = 17'd10;
         default: divisor = 17'd1;
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               case (acc)
                  16'd0:   state_next = HALTED;
                  16'd1:   state_next = R_SKIP;
                  16'd2:   state_next = W_SIGN;
                  default: state_next = IDLE;
               endcase
            end
         end
         HALTED:  state_next = HALTED;
         W_SIGN:  state_next = W_DIGIT;
         // Leave on the last subtraction so a digit never exceeds 10 cycles
         W_DIGIT: if (!mag_ge || (mag_rem < divisor)) state_next = W_EMIT;
         W_EMIT: begin
            if (!emit_digit || tx_free)
               state_next = (pos_q == 3'd4) ? W_NL : W_DIGIT;
         end
         W_NL:    if (nl_sent_q && tx_valid && tx_ready) state_next = DONE;
         R_SKIP: begin
            if (rx_fire && !rx_is_ws)
               state_next = (rx_is_minus || rx_is_digit) ? R_DIGIT : DONE;
         end
         R_DIGIT: if (rx_fire && !rx_is_digit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic decoded from state
   always_comb begin
      rx_ready = (state == R_SKIP) || (state == R_DIGIT);
   end

   // Registered status outputs and READ result
   always_ff @(posedge clock) begin
      if (!reset) begin
         iobusy    <= 1'b0;
         halted    <= 1'b0;
         io_result <= '0;
      end else begin
         iobusy <= (state_next != IDLE);
         halted <= (state_next == HALTED);
         if ((state == DONE) && (code_q == 16'd1))
            io_result <= neg_q ? (16'd0 - val_q) : val_q;
      end
   end

   // Transmit byte register: holds until accepted, then loads the next byte
   always_ff @(posedge clock) begin
      if (!reset) begin
         tx_valid <= 1'b0;
         tx_data  <= '0;
      end else begin
         if (tx_valid && tx_ready) tx_valid <= 1'b0;
         if ((state == W_SIGN) && neg_q) begin
            tx_data  <= 8'h2D;
            tx_valid <= 1'b1;
         end
         if ((state == W_EMIT) && emit_digit && tx_free) begin
            tx_data  <= 8'h30 + {4'd0, cnt_q};
            tx_valid <= 1'b1;
         end
         if ((state == W_NL) && !nl_sent_q && tx_free) begin
            tx_data  <= 8'h0A;
            tx_valid <= 1'b1;
         end
      end
   end

   // Conversion datapath for both directions
   always_ff @(posedge clock) begin
      if (!reset) begin
         code_q    <= '0;
         neg_q     <= 1'b0;
         mag_q     <= '0;
         pos_q     <= '0;
         cnt_q     <= '0;
         lead_q    <= 1'b0;
         nl_sent_q <= 1'b0;
         val_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  code_q    <= acc;
                  neg_q     <= (acc == 16'd2) && dr[15];
                  mag_q     <= dr[15] ? (17'd0 - {1'b1, dr}) : {1'b0, dr};
                  pos_q     <= '0;
                  cnt_q     <= '0;
                  lead_q    <= 1'b0;
                  nl_sent_q <= 1'b0;
                  val_q     <= '0;
               end
            end
            W_DIGIT: begin
               if (mag_ge) begin
                  mag_q <= mag_rem;
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            W_EMIT: begin
               if (!emit_digit || tx_free) begin
                  if (emit_digit) lead_q <= 1'b1;
                  pos_q <= pos_q + 3'd1;
                  cnt_q <= '0;
               end
            end
            W_NL: if (!nl_sent_q && tx_free) nl_sent_q <= 1'b1;
            R_SKIP: begin
               if (rx_fire) begin
                  if (rx_is_minus)      neg_q <= 1'b1;
                  else if (rx_is_digit) val_q <= {12'd0, rx_data[3:0]};
               end
            end
            R_DIGIT: if (rx_fire && rx_is_digit) val_q <= val_acc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sextium_io.sv
// Self-checking bench for sextium_io: behavioural text model plus per-cycle
// protocol/status comparison and hand-computed literal cases.
module tb_sextium_io;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        runio = 1'b0;
   logic [15:0] acc = '0;
   logic [15:0] dr = '0;
   logic        iobusy, halted, tx_valid, rx_ready;
   logic [15:0] io_result;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   sextium_io dut (
      .clock(clock), .reset(reset), .runio(runio), .acc(acc), .dr(dr),
      .iobusy(iobusy), .halted(halted), .io_result(io_result),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
   );

   always #5 clock = ~clock;

   // model / stimulus state
   logic [15:0] exp_io = '0;
   bit          exp_halted = 0;
   logic [15:0] exp_read = '0;
   int          cur_op = -1;
   byte         got[$];
   int          n_cons = 0;
   string       rx_str = "";
   bit          rx_active = 0;
   int          tx_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic string hexs(input string s);
      string r = "";
      for (int i = 0; i < s.len(); i++) r = {r, $sformatf("%02h ", s[i])};
      return r;
   endfunction

   task automatic check_str(input string name, input string act, input string req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got [%s] expected [%s]", name, hexs(act), hexs(req));
      end
   endtask

   // Decimal text parse following the READ rules
   function automatic void read_model(input string s, output logic [15:0] res, output int cons);
      int i = 0;
      bit neg = 0;
      logic [15:0] v = '0;
      byte c;
      res = '0;
      while (i < s.len() && (s[i] == 8'h20 || s[i] == 8'h09 || s[i] == 8'h0A || s[i] == 8'h0D)) i++;
      if (i >= s.len()) begin cons = i; return; end
      c = s[i]; i++;
      if (c == 8'h2D) neg = 1;
      else if (c >= 8'h30 && c <= 8'h39) v = {12'd0, c[3:0]};
      else begin cons = i; return; end
      while (i < s.len()) begin
         c = s[i]; i++;
         if (c >= 8'h30 && c <= 8'h39) v = v * 16'd10 + {12'd0, c[3:0]};
         else break;
      end
      cons = i;
      res = neg ? (16'd0 - v) : v;
   endfunction

   // Per-cycle compare process
   bit         pv = 0, pr = 0, pbusy = 0, start_pend = 0, rst_pend = 0, armed = 0;
   logic [7:0] pd = '0;
   logic [15:0] start_code = '0;
   always @(negedge clock) begin
      if (rst_pend) begin
         check("reset_outputs", {iobusy, halted, io_result, tx_data, tx_valid, rx_ready}, '0);
         exp_io = '0;
         exp_halted = 0;
         armed = 1;
      end else if (armed) begin
         if (start_pend) check("busy_after_start", iobusy, start_code <= 16'd2);
         if (start_pend && start_code == 16'd0) exp_halted = 1;
         if (pbusy && !iobusy && cur_op == 1) exp_io = exp_read;
         check("io_result", io_result, exp_io);
         check("halted", halted, exp_halted);
         if (pv && !pr) check("tx_hold", {tx_valid, tx_data}, {1'b1, pd});
         if (!iobusy) check("rx_ready_idle", rx_ready, 1'b0);
      end
      if (reset && tx_valid && tx_ready) got.push_back(tx_data);
      if (reset && rx_valid && rx_ready) n_cons++;
      start_pend = reset && runio && !iobusy && !exp_halted;
      start_code = acc;
      rst_pend = !reset;
      pv = tx_valid; pr = tx_ready; pd = tx_data; pbusy = iobusy;
   end

   // Byte source and sink drivers
   always @(posedge clock) begin
      #1;
      if (rx_active && n_cons < rx_str.len()) begin
         rx_data  = rx_str[n_cons];
         rx_valid = ($urandom_range(0, 3) != 0);
      end else begin
         rx_valid = 1'b0;
      end
      case (tx_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         default: tx_ready = $urandom_range(0, 1);
      endcase
   end

   task automatic run_op(input logic [15:0] code, input logic [15:0] arg);
      @(posedge clock); #1;
      cur_op = code;
      acc = code; dr = arg; runio = 1'b1;
      @(posedge clock); #1;
      runio = 1'b0; acc = $urandom; dr = $urandom;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (iobusy && k < 3000) begin @(negedge clock); k++; end
      if (iobusy) begin
         n_checks++; n_fail++;
         $display("FAIL %s_timeout: got iobusy 1 expected 0", name);
      end
      @(posedge clock); #1;
   endtask

   task automatic do_write(input logic [15:0] arg, input int mode, input string req, input string name);
      string s = "";
      tx_mode = mode;
      got.delete();
      run_op(16'd2, arg);
      wait_idle(name);
      foreach (got[i]) s = {s, $sformatf("%c", got[i])};
      check_str(name, s, req);
   endtask

   task automatic do_read(input string str, input logic [15:0] req_res, input int req_cons, input string name);
      logic [15:0] mres;
      int mcons;
      read_model(str, mres, mcons);
      exp_read = mres;
      rx_str = str; n_cons = 0; rx_active = 1;
      run_op(16'd1, $urandom);
      wait_idle(name);
      check({name, "_result"}, io_result, req_res);
      check({name, "_consumed"}, n_cons, req_cons);
      check({name, "_rx_ready"}, rx_ready, 1'b0);
      rx_active = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      shortint sv;
      logic [15:0] w, mres;
      int mcons, n;
      string s;
      string ws[4] = '{" ", "\t", "\n", "\r"};
      string terms[4] = '{" ", "\n", ",", "x"};

      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      do_read("  -42\n", 16'hFFD6, 6, "read_m42");
      do_write(16'd0, 0, "0\n", "write_zero");
      check("io_after_write", io_result, 16'hFFD6);
      do_write(16'h8000, 0, "-32768\n", "write_min");
      do_write(16'd1205, 1, "1205\n", "write_1205_stall");
      do_read("70000 ", 16'd4464, 6, "read_wrap");
      do_read("x", 16'd0, 1, "read_garbage");
      do_read("-;", 16'd0, 2, "read_minus_only");

      for (int i = 0; i < 25; i++) begin
         w = $urandom;
         sv = w;
         do_write(w, 2, $sformatf("%0d\n", sv), "write_rand");
      end
      for (int i = 0; i < 25; i++) begin
         s = "";
         n = $urandom_range(0, 99999);
         repeat ($urandom_range(0, 3)) s = {s, ws[$urandom_range(0, 3)]};
         if ($urandom_range(0, 2) == 0) s = {s, "-"};
         s = {s, $sformatf("%0d", n), terms[$urandom_range(0, 3)]};
         if ($urandom_range(0, 7) == 0) s = "-q";
         read_model(s, mres, mcons);
         do_read(s, mres, mcons, "read_rand");
      end

      run_op(16'd7, 16'd3);
      repeat (4) begin
         check("noop_busy", iobusy, 1'b0);
         @(posedge clock); #1;
      end

      run_op(16'd0, 16'd0);
      repeat (2) @(posedge clock);
      #1;
      check("halt_flags", {halted, iobusy}, 2'b11);
      repeat (3) begin
         acc = 16'd2; dr = 16'd5; runio = 1'b1;
         @(posedge clock); #1;
         runio = 1'b0;
         @(posedge clock); #1;
      end
      check("halt_persist", {halted, iobusy, tx_valid}, 3'b110);
      reset = 1'b0;
      @(posedge clock); #1;
      check("halt_cleared", {halted, iobusy}, 2'b00);
      reset = 1'b1;
      @(posedge clock); #1;

      tx_mode = 0;
      got.delete();
      run_op(16'd2, 16'd12345);
      k = 0;
      while (got.size() < 2 && k < 500) begin @(posedge clock); #1; k++; end
      k = 0;
      while (!tx_valid && k < 500) begin @(posedge clock); #1; k++; end
      check("third_byte_pending", {tx_valid, tx_data}, {1'b1, 8'h33});
      reset = 1'b0;
      @(posedge clock); #1;
      check("abort_outputs", {iobusy, halted, io_result, tx_data, tx_valid, rx_ready}, '0);
      check("bytes_before_abort", got.size(), 2);
      reset = 1'b1;
      @(posedge clock); #1;
      do_write(16'd5, 0, "5\n", "write_after_abort");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sextium_io.md
# sextium_io

Syscall I/O unit for the Sextium III core. It sits downstream of the instruction controller: the controller raises `runio` on a SYSCALL and waits in IOWAIT while `iobusy` is high. The unit reads the syscall code from ACC and the argument from DR, and performs HALT, READ or WRITE. READ and WRITE use decimal ASCII over two byte-stream handshakes, and the READ result is returned on `io_result` for the accumulator's IO input.

## Interface
Parameters: none; data width fixed at 16.

Ports:
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-low
- `runio`  in  1  start request from controller (ignored unless IDLE)
- `acc`  in  16  syscall code; only values 0–2 are defined
- `dr`  in  16  WRITE argument, two's complement
- `iobusy`  out  1  registered; high while a syscall is in progress
- `halted`  out  1  high after HALT until reset
- `io_result`  out  16  READ result
- `tx_data`  out  8  output byte
- `tx_valid`  out  1  output byte valid
- `tx_ready`  in  1  sink accepts the byte
- `rx_data`  in  8  input byte
- `rx_valid`  in  1  input byte valid
- `rx_ready`  out  1  unit consumes the byte

## Operation
- States: IDLE, HALTED, W_SIGN, W_DIGIT, W_EMIT, W_NL, R_SKIP, R_DIGIT, DONE.
- Start condition: IDLE && `runio` && !`iobusy`. On start the unit latches `acc` and `dr`.
  - Code 0 (HALT) → HALTED; `iobusy` and `halted` go to 1 and stay there until reset.
  - Code 1 (READ) → R_SKIP; `iobusy`=1.
  - Code 2 (WRITE) → W_SIGN; `iobusy`=1.
  - Any other code → no-op; stay IDLE with `iobusy`=0.
- WRITE:
  - If `dr` is negative, emit `-` (0x2D) first.
  - Magnitude is held in 17 bits, so -32768 converts to 32768.
  - Digits are produced by repeated subtraction of 10000, 1000, 100, 10, 1, most significant first.
  - Leading zeros are suppressed; a value of 0 emits a single `0`.
  - Finish with 0x0A, then go to DONE.
- READ:
  - R_SKIP consumes space, tab, LF and CR.
  - A single `-` sets the negate flag and moves to R_DIGIT.
  - A digit moves to R_DIGIT and starts accumulation.
  - Any other byte is consumed and ends the syscall with result 0.
  - R_DIGIT accumulates value = value*10 + d, modulo 2^16.
  - The first non-digit byte is consumed and terminates the read. `-` followed directly by a non-digit terminates with result 0.
  - Result = negate ? -value : value, modulo 2^16.
- DONE: `iobusy`→0 and return to IDLE.

## Timing
- Reset values: every output 0; state IDLE. `io_result` is not updated by HALT, WRITE or no-op.
- `iobusy` rises on the clock edge after the start cycle. This guarantees the controller samples it high in its first IOWAIT cycle.
- `tx_valid` and `tx_data` are registered. Once `tx_valid` is high, `tx_data` holds until the cycle where `tx_valid && tx_ready`; the next byte may appear no earlier than the following cycle.
- `rx_ready` is high only in R_SKIP and R_DIGIT. A byte is consumed when `rx_valid && rx_ready`, and at most one byte is consumed per cycle.
- Each digit conversion takes at most 10 cycles (max 9 subtractions plus 1 emit setup), independent of handshake stalls.
- `io_result` is written on the same edge that drops `iobusy`, and holds until the next READ completes.
- `runio` while busy or HALTED is ignored.
- Reset mid-operation aborts the syscall: any byte in flight is dropped and no partial `io_result` is written.

## Test plan
- WRITE `dr`=0, `tx_ready`=1 → bytes 0x30, 0x0A; `iobusy` then falls; `io_result` unchanged.
- WRITE `dr`=0x8000 → bytes `-32768\n`. Then WRITE 1205 with `tx_ready` toggling every other cycle → `1205\n`, with `tx_data` stable across every stall.
- READ input `"  -42\n"` → `io_result`=0xFFD6; exactly 6 bytes consumed; `rx_ready` low after completion.
- READ input `"70000 "` → `io_result`=4464 (wrap). READ input `"x"` → `io_result`=0, 1 byte consumed.
- `acc`=0 → `halted`=1 and `iobusy`=1 persist; later `runio` pulses have no effect; reset clears both. `acc`=7 → `iobusy` never rises.
- Assert reset during the 3rd byte of a WRITE → all outputs 0 the next cycle; a new WRITE of 5 emits `5\n` only.
